mp_array: RTL
=============

MP_ARRAY -- requirements
Module: mp_array

Interface
REQ-001 SHALL have parameter CH, default 16, number of pooled channels.
REQ-002 SHALL have parameter DW, default 8, element width in bits.
REQ-003 SHALL have parameter SIGNED, default 0; 0 compares unsigned, 1 compares two's complement.
REQ-004 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port clear, input, 1, synchronous abort of the partial window and flush of the output buffer.
REQ-007 SHALL have port cfg_len, input, 16, beats reduced per output; sampled on the first beat of each window.
REQ-008 SHALL have port in_valid, input, 1, input beat valid.
REQ-009 SHALL have port in_ready, output, 1, input beat accepted when in_valid && in_ready.
REQ-010 SHALL have port in_data, input, CH*4*DW; channel c lane k = in_data[(c*4+k)*DW +: DW], k=0..3 (one 2x2 window).
REQ-011 SHALL have port out_valid, output, 1, result available.
REQ-012 SHALL have port out_ready, input, 1, result consumed when out_valid && out_ready.
REQ-013 SHALL have port out_data, output, CH*DW; channel c = out_data[c*DW +: DW], strictly ascending order, no duplicated or missing channel.
REQ-014 SHALL have port busy, output, 1, high while a window is partially accumulated.

Function
REQ-015 Per accepted beat, each channel SHALL form the max of its 4 lanes using the SIGNED compare rule.
REQ-016 First beat of a window SHALL load the running max; later beats SHALL replace it only if strictly greater.
REQ-017 Beat counter SHALL count accepted beats; when count reaches the latched length, the running max SHALL be pushed to the output buffer and the counter SHALL return to 0.
REQ-018 cfg_len = 0 SHALL be treated as 1; cfg_len changes mid-window SHALL be ignored until the next window.
REQ-019 State machine: IDLE (count 0) -> ACC on an accepted beat with len > 1; ACC -> IDLE on the final beat; IDLE -> IDLE when len = 1 (push every beat).
REQ-020 Output buffer SHALL be a 2-entry FIFO; out_valid SHALL assert the cycle after the final beat of a window is accepted (latency 1).
REQ-021 in_ready SHALL equal (fifo count < 2) && !clear, registered-only, with no combinational path from out_ready.
REQ-022 Simultaneous push and pop SHALL leave the count unchanged and preserve order.
REQ-023 out_data SHALL hold stable while out_valid && !out_ready.
REQ-024 clear SHALL zero the counter, empty the FIFO, deassert busy, and take priority over a same-cycle beat or pop.
REQ-025 busy SHALL be high exactly while in ACC.

Reset
REQ-026 reset_n low SHALL asynchronously force state IDLE, counter 0, FIFO empty, out_valid 0, busy 0, out_data 0, and running max 0.
REQ-027 Reset mid-window SHALL discard the partial result; in_ready SHALL be 1 on the first edge after release.

Structure
REQ-028 Shared package mp_pkg SHALL hold the default DW/CH constants, the state enumeration (IDLE, ACC), and the signed/unsigned max function.
REQ-029 Sub-module mp_lane SHALL implement one channel: 4:1 max tree plus running-max register, instantiated CH times via generate.
REQ-030 Counter, FSM, and FIFO SHALL be shared by all channels in the top level.

Verification
REQ-031 CH=2, DW=8, SIGNED=0, cfg_len=1, ch0 lanes {3,9,1,7}, ch1 lanes {200,5,255,0} -> one cycle later out_data ch0=9, ch1=255, out_valid=1.
REQ-032 SIGNED=1, ch0 lanes {0x80,0xFF,0x01,0x7F} -> ch0=0x7F; the same data with SIGNED=0 -> 0xFF.
REQ-033 cfg_len=3, beats with ch0 maxima 4, 12, 7 -> a single output of 12 after the third beat; busy high after beats 1-2, low after beat 3.
REQ-034 out_ready=0, cfg_len=1, continuous in_valid -> exactly 2 beats accepted, then in_ready=0; with out_ready=1, results arrive in order with no loss.
REQ-035 reset_n pulsed low after beat 1 of a cfg_len=4 window -> no output; the next 4 beats yield the max of only those 4.
REQ-036 clear asserted with in_valid high and FIFO holding 1 entry -> FIFO empty, busy 0, the beat is not accepted, out_valid 0 next cycle.

Source files
------------

// File: rtl/mp_pkg.sv
// mp_pkg: shared constants, FSM states and the signed/unsigned max helper for mp_array
package mp_pkg;
    localparam int DW_DEF = 8;
    localparam int CH_DEF = 16;
    localparam int XW = 64;
    typedef enum logic {IDLE, ACC} state_t;
    function automatic logic [XW-1:0] max_x(input logic [XW-1:0] a, input logic [XW-1:0] b, input logic sgn);
        return (sgn ? ($signed(a) > $signed(b)) : (a > b)) ? a : b;
    endfunction
endpackage

// File: rtl/mp_lane.sv
// mp_lane: one channel of mp_array, 4:1 max tree feeding a running-max register
module mp_lane
    import mp_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int SIGNED = 0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            en,
    input  logic            first,
    input  logic [4*DW-1:0] lanes,
    output logic [DW-1:0]   nxt
);
    localparam logic SG = SIGNED != 0;
    logic [DW-1:0] run;
    logic [XW-1:0] m01, m23, mb, mr;
    function automatic logic [XW-1:0] ext(input logic [DW-1:0] v);
        return SG ? {{(XW-DW){v[DW-1]}}, v} : {{(XW-DW){1'b0}}, v};
    endfunction
    always_comb begin
        m01 = max_x(ext(lanes[0 +: DW]), ext(lanes[DW +: DW]), SG);
        m23 = max_x(ext(lanes[2*DW +: DW]), ext(lanes[3*DW +: DW]), SG);
        mb  = max_x(m01, m23, SG);
        mr  = first ? mb : max_x(ext(run), mb, SG);
    end
    assign nxt = mr[DW-1:0];
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) run <= '0;
        else if (en) run <= nxt;
endmodule

// File: rtl/mp_array.sv
// mp_array: multi-channel 2x2 max pooling over cfg_len beats with a 2-entry output FIFO
module mp_array
    import mp_pkg::*;
#(
    parameter int CH = CH_DEF,
    parameter int DW = DW_DEF,
    parameter int SIGNED = 0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic [15:0]        cfg_len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CH*4*DW-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CH*DW-1:0]   out_data,
    output logic               busy
);
    state_t state_q, state_d;
    logic [15:0] cnt_q, cnt_d, len_q, len_d, len_eff;
    logic [1:0] fcnt;
    logic wp, rp, acc, fin, pop, first;
    logic [CH*DW-1:0] mem [2];
    logic [CH*DW-1:0] push_data;
    assign first     = state_q == IDLE;
    assign in_ready  = fcnt != 2'd2 && !clear;
    assign acc       = in_valid && in_ready;
    assign len_eff   = cfg_len == 16'd0 ? 16'd1 : cfg_len;
    assign fin       = acc && (cnt_q + 16'd1 == (first ? len_eff : len_q));
    assign out_valid = fcnt != 2'd0;
    assign pop       = out_valid && out_ready;
    assign busy      = state_q == ACC;
    assign out_data  = mem[rp];
    for (genvar c = 0; c < CH; c++) begin : g_lane
        mp_lane #(.DW(DW), .SIGNED(SIGNED)) u_lane (
            .clk    (clk),
            .reset_n(reset_n),
            .en     (acc),
            .first  (first),
            .lanes  (in_data[c*4*DW +: 4*DW]),
            .nxt    (push_data[c*DW +: DW])
        );
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (acc) begin
            state_d = fin ? IDLE : ACC;
            cnt_d   = fin ? 16'd0 : cnt_q + 16'd1;
            len_d   = first ? len_eff : len_q;
        end
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= 16'd1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            fcnt   <= '0;
            wp     <= 1'b0;
            rp     <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (clear) begin
            fcnt <= '0;
            wp   <= 1'b0;
            rp   <= 1'b0;
        end else begin
            if (fin) begin
                mem[wp] <= push_data;
                wp      <= ~wp;
            end
            if (pop) rp <= ~rp;
            fcnt <= fcnt + {1'b0, fin} - {1'b0, pop};
        end
endmodule
